keystream_xor_engine: RTL and testbench
=======================================

// Module: keystream_xor_engine
// PURPOSE
// - Stream-cipher stage sitting directly upstream of the output holding stage.
// - Accepts one plaintext/ciphertext byte at a time from the interface logic.
// - XORs the byte with 8 keystream bits produced serially by a 16-bit Fibonacci LFSR.
// - Emits the result as data_out with a one-cycle data_out_pulse, which the holding stage latches.
// - Same key + same byte sequence gives the same keystream, so one engine both encrypts and decrypts.
// PARAMETERS
// - SEED_DEFAULT   16'hACE1   LFSR reset value; also substituted when a zero key is loaded.
// PORTS
// - clk             in   1    system clock, all state on rising edge
// - nrst            in   1    asynchronous active-low reset
// - key_in          in   16   key/seed value, sampled when key_load is accepted
// - key_load        in   1    single-cycle request to seed the LFSR from key_in
// - data_in         in   8    input byte, sampled when data_in_valid is accepted
// - data_in_valid   in   1    single-cycle request to process data_in
// - busy            out  1    high while a byte is being processed (state SHIFT)
// - data_out        out  8    last result byte; held until the next result
// - data_out_pulse  out  1    high exactly one cycle when data_out is updated
// BEHAVIOUR
// - Reset (async, nrst=0):
//   - state=IDLE, lfsr=SEED_DEFAULT, bit count=0, ks=0, data_reg=0.
//   - Outputs: data_out=0, data_out_pulse=0, busy=0.
//   - Reset mid-operation aborts the byte; no pulse is produced.
// - States: IDLE, SHIFT. busy = (state==SHIFT).
// - IDLE, key_load=1: lfsr <= (key_in==0) ? SEED_DEFAULT : key_in. State stays IDLE.
// - IDLE, data_in_valid=1 (edge E0):
//   - data_reg <= data_in; ks <= 0; count <= 0; state <= SHIFT.
// - IDLE, key_load and data_in_valid in the same cycle:
//   - Both take effect at the same edge: the new key seeds the LFSR and the byte uses the new key.
//   - Keystream shifting starts from the new seed at E1.
// - SHIFT, each edge E1..E8:
//   - bit = lfsr[15]; fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
//   - lfsr <= {lfsr[14:0], fb}; ks <= {ks[6:0], bit}; count <= count+1.
// - At E8 (count==7):
//   - data_out <= data_reg ^ {ks[6:0], bit}; data_out_pulse <= 1; state <= IDLE.
// - data_out_pulse is high for the cycle following E8 only. It is cleared on every other edge.
// - Latency: accept edge E0 -> pulse visible after E8 (8 cycles).
//   - Next byte may be accepted at E9; max throughput 1 byte / 9 cycles.
// - SHIFT, data_in_valid or key_load asserted: ignored/dropped (no queueing). LFSR and in-flight byte are unaffected.
// - LFSR state persists across bytes; keystream continues, it is not re-seeded per byte.
// - LFSR can never hold 0: reset value and loads are non-zero, and the taps are maximal length (period 65535).
// - data_out is never cleared except by reset.
// TESTING
// - Reset value: assert nrst=0 mid-SHIFT.
//   - Required: busy=0, data_out=0, data_out_pulse=0 immediately.
//   - Required: lfsr=16'hACE1 after release.
// - Key 0x0001 loaded, byte 0xA5 in:
//   - Required: busy high for 8 cycles, then pulse with data_out=0xA5; lfsr=0x0100.
// - Continue from the previous case, byte 0x00 in:
//   - Required: data_out=0x01; lfsr=0x002D. Confirms keystream continuation.
// - Round trip: load key K, encrypt 16 random bytes; reload K, feed the ciphertexts.
//   - Required: original bytes returned. Also run with K=0 to confirm the 0xACE1 substitution.
// - data_in_valid and key_load pulsed at E3 of a SHIFT.
//   - Required: both dropped; result and lfsr match the undisturbed run.
// - key_load and data_in_valid in the same IDLE cycle with key 0x0001, byte 0x3C:
//   - Required: data_out=0x3C (new key used).

Source files
------------

// File: rtl/keystream_xor_engine_if.sv
// Byte/key handshake bundle between the interface logic and the keystream XOR engine.
// master drives requests into the engine, slave is the engine side.
interface keystream_xor_engine_if;
  logic [15:0] key_in;
  logic        key_load;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        busy;
  logic [7:0]  data_out;
  logic        data_out_pulse;

  modport master (
    output key_in, key_load, data_in, data_in_valid,
    input  busy, data_out, data_out_pulse
  );

  modport slave (
    input  key_in, key_load, data_in, data_in_valid,
    output busy, data_out, data_out_pulse
  );
endinterface

// File: rtl/keystream_xor_engine.sv
// Stream-cipher stage: XORs each accepted byte with 8 serial keystream bits from a
// 16-bit Fibonacci LFSR (taps 15,13,12,10); the same engine encrypts and decrypts.
module keystream_xor_engine #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input logic                   clk,
  input logic                   nrst,
  keystream_xor_engine_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Feedback is the parity of the tapped bits; the tap set is maximal length.
  function automatic logic lfsr_fb(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

  state_t      state_r, state_s;
  logic [15:0] lfsr_r, lfsr_s;
  logic [7:0]  ks_r, ks_s;
  logic [2:0]  count_r, count_s;
  logic [7:0]  data_reg_r, data_reg_s;
  logic [7:0]  data_out_r, data_out_s;
  logic        pulse_r, pulse_s;
  logic        busy_r;
  logic        bit_s;

  // Next-state and datapath decode for the IDLE/SHIFT sequencer.
  always_comb begin
    state_s    = state_r;
    lfsr_s     = lfsr_r;
    ks_s       = ks_r;
    count_s    = count_r;
    data_reg_s = data_reg_r;
    data_out_s = data_out_r;
    pulse_s    = 1'b0;
    bit_s      = lfsr_r[15];
    case (state_r)
      ST_IDLE: begin
        // A key loaded alongside a byte seeds the LFSR at the same edge the byte is taken.
        if (bus.key_load) begin
          lfsr_s = (bus.key_in == 16'h0000) ? SEED_DEFAULT : bus.key_in;
        end else begin
          lfsr_s = lfsr_r;
        end
        if (bus.data_in_valid) begin
          data_reg_s = bus.data_in;
          ks_s       = 8'h00;
          count_s    = 3'd0;
          state_s    = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        lfsr_s  = {lfsr_r[14:0], lfsr_fb(lfsr_r)};
        ks_s    = {ks_r[6:0], bit_s};
        count_s = count_r + 3'd1;
        if (count_r == 3'd7) begin
          data_out_s = data_reg_r ^ {ks_r[6:0], bit_s};
          pulse_s    = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; busy is registered from the next state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= ST_IDLE;
      lfsr_r     <= SEED_DEFAULT;
      ks_r       <= 8'h00;
      count_r    <= 3'd0;
      data_reg_r <= 8'h00;
      data_out_r <= 8'h00;
      pulse_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      lfsr_r     <= lfsr_s;
      ks_r       <= ks_s;
      count_r    <= count_s;
      data_reg_r <= data_reg_s;
      data_out_r <= data_out_s;
      pulse_r    <= pulse_s;
      busy_r     <= (state_s == ST_SHIFT);
    end
  end

  assign bus.busy           = busy_r;
  assign bus.data_out       = data_out_r;
  assign bus.data_out_pulse = pulse_r;

endmodule

// File: tb/tb_keystream_xor_engine.sv
// Scoreboard bench for keystream_xor_engine: stimulus pushes expected bytes from a
// bit-serial keystream model; a negedge monitor pops and compares on every pulse.
module tb_keystream_xor_engine;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic clk;
  logic nrst;
  keystream_xor_engine_if kif();

  keystream_xor_engine dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  sbq[$];
  logic [15:0] model_lfsr;
  logic [7:0]  last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Keystream model: take the top bit, shift in the parity of the tapped bits.
  task automatic model_encrypt(input logic [7:0] d, output logic [7:0] r);
    logic [7:0] ks;
    ks = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ks = {ks[6:0], model_lfsr[15]};
      model_lfsr = {model_lfsr[14:0], ^(model_lfsr & TAPS)};
    end
    r = d ^ ks;
  endtask

  // One IDLE request (key, byte or both); for a byte, check busy through E0..E7,
  // optionally injecting dropped requests during the shift.
  task automatic do_op(input bit ld, input logic [15:0] k, input bit dv, input logic [7:0] d,
                       input bit ovr, input logic [7:0] ovr_val, input int inject);
    logic [7:0] e;
    @(negedge clk);
    kif.key_load      = ld;
    kif.key_in        = k;
    kif.data_in_valid = dv;
    kif.data_in       = d;
    if (ld) model_lfsr = (k == 16'h0000) ? SEED : k;
    if (dv) begin
      model_encrypt(d, e);
      last_exp = e;
      sbq.push_back(ovr ? ovr_val : e);
    end
    @(posedge clk);
    #1;
    kif.key_load      = 1'b0;
    kif.data_in_valid = 1'b0;
    if (dv) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("busy_in_shift", {31'd0, kif.busy}, 32'd1);
        if (i == inject) begin
          kif.key_load      = 1'b1;
          kif.key_in        = 16'h1234;
          kif.data_in_valid = 1'b1;
          kif.data_in       = ~d;
        end else begin
          kif.key_load      = 1'b0;
          kif.data_in_valid = 1'b0;
        end
      end
    end
  endtask

  // Monitor: every result pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (nrst === 1'b1 && kif.data_out_pulse === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        chk("data_out", {24'd0, kif.data_out}, {24'd0, sbq.pop_front()});
        chk("busy_at_pulse", {31'd0, kif.busy}, 32'd0);
      end
    end
  end

  logic [7:0]  orig[16];
  logic [7:0]  ciph[16];
  logic [15:0] key_list[2];

  initial begin
    nrst              = 1'b0;
    kif.key_in        = 16'h0000;
    kif.key_load      = 1'b0;
    kif.data_in       = 8'h00;
    kif.data_in_valid = 1'b0;
    model_lfsr        = SEED;
    #1;
    chk("rst_busy", {31'd0, kif.busy}, 32'd0);
    chk("rst_data_out", {24'd0, kif.data_out}, 32'd0);
    chk("rst_pulse", {31'd0, kif.data_out_pulse}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_lfsr", {16'd0, dut.lfsr_r}, {16'd0, SEED});

    // Known-answer: key 0x0001 gives zero keystream for the first byte.
    do_op(1'b1, 16'h0001, 1'b1, 8'hA5, 1'b1, 8'hA5, -1);
    @(negedge clk);
    chk("lfsr_after_a5", {16'd0, dut.lfsr_r}, 32'h0000_0100);
    do_op(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 8'h01, -1);
    @(negedge clk);
    chk("lfsr_after_00", {16'd0, dut.lfsr_r}, 32'h0000_002D);

    // Round trip with a random key and with the zero key (seed substitution).
    key_list[0] = 16'($urandom_range(1, 65535));
    key_list[1] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      do_op(1'b1, key_list[k], 1'b0, 8'h00, 1'b0, 8'h00, -1);
      if (key_list[k] == 16'h0000) begin
        @(negedge clk);
        chk("zero_key_seed", {16'd0, dut.lfsr_r}, {16'd0, SEED});
      end
      for (int i = 0; i < 16; i++) begin
        orig[i] = 8'($urandom);
        do_op(1'b0, 16'h0000, 1'b1, orig[i], 1'b0, 8'h00, -1);
        ciph[i] = last_exp;
      end
      do_op(1'b1, key_list[k], 1'b0, 8'h00, 1'b0, 8'h00, -1);
      for (int i = 0; i < 16; i++) begin
        do_op(1'b0, 16'h0000, 1'b1, ciph[i], 1'b1, orig[i], -1);
      end
    end

    // Requests arriving at E3 of a shift are dropped.
    do_op(1'b1, 16'h5A5A, 1'b0, 8'h00, 1'b0, 8'h00, -1);
    do_op(1'b0, 16'h0000, 1'b1, 8'hC3, 1'b0, 8'h00, 2);
    @(negedge clk);
    chk("lfsr_after_drop", {16'd0, dut.lfsr_r}, {16'd0, model_lfsr});
    do_op(1'b0, 16'h0000, 1'b1, 8'h96, 1'b0, 8'h00, -1);

    // Key and byte in the same IDLE cycle: byte uses the new key.
    do_op(1'b1, 16'h0001, 1'b1, 8'h3C, 1'b1, 8'h3C, -1);

    // Reset in the middle of a shift aborts the byte with no pulse.
    @(negedge clk);
    kif.data_in       = 8'h77;
    kif.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    kif.data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", {31'd0, kif.busy}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, kif.busy}, 32'd0);
    chk("abort_data_out", {24'd0, kif.data_out}, 32'd0);
    chk("abort_pulse", {31'd0, kif.data_out_pulse}, 32'd0);
    model_lfsr = SEED;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("abort_lfsr", {16'd0, dut.lfsr_r}, {16'd0, SEED});
    repeat (12) @(negedge clk);
    do_op(1'b0, 16'h0000, 1'b1, 8'h5E, 1'b0, 8'h00, -1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
